// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with a KMP-style prefix state machine,
// selectable Mealy/Moore output, overlap mode and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter bit               OVERLAP = 1'b0,
  parameter bit               MOORE   = 1'b0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int SW = $clog2(PAT_W + 1);
  localparam int NS = 1 << SW;

  // Longest pattern prefix that is a suffix of (prefix of length s) ++ b.
  function automatic int kmp_next(input int s, input int b);
    int   res;
    int   j;
    logic ok;
    logic tb;
    res = 0;
    if (s < PAT_W) begin
      for (int k = 1; k <= s + 1; k++) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          j  = s + 1 - k + i;
          tb = (j < s) ? PATTERN[PAT_W-1-j] : b[0];
          if (PATTERN[PAT_W-1-i] != tb) ok = 1'b0;
        end
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int fail_len();
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (PATTERN[PAT_W-1-i] != PATTERN[k-1-i]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  localparam int            FAIL_FULL = fail_len();
  localparam logic [SW-1:0] LAST_S    = SW'(PAT_W - 1);
  localparam logic [SW-1:0] FULL_S    = SW'(PAT_W);
  localparam logic [SW-1:0] RESTART_S = OVERLAP ? SW'(FAIL_FULL) : {SW{1'b0}};

  logic [SW-1:0]    state_r;
  logic [SW-1:0]    eff_s;
  logic [SW-1:0]    next_s;
  logic             done_s;
  logic [CNT_W-1:0] cnt_r;
  logic [SW-1:0]    tbl_s [NS][2];

  // Transition table folded to constants at elaboration.
  for (genvar gs = 0; gs < NS; gs++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      assign tbl_s[gs][gb] = SW'(kmp_next(gs, gb));
    end
  end

  // Effective state: a held Moore full match resumes from the restart point.
  always_comb begin
    eff_s = state_r;
    if (MOORE && (state_r == FULL_S)) begin
      eff_s = RESTART_S;
    end else begin
      eff_s = state_r;
    end
  end

  // Completion detect and next-state selection.
  always_comb begin
    done_s = en & (eff_s == LAST_S) & (din == PATTERN[0]);
    next_s = state_r;
    if (!en) begin
      next_s = state_r;
    end else if (done_s) begin
      next_s = MOORE ? FULL_S : RESTART_S;
    end else begin
      next_s = tbl_s[eff_s][din];
    end
  end

  // Prefix-length state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= {SW{1'b0}};
    end else begin
      state_r <= next_s;
    end
  end

  // Saturating match counter; clear beats a coincident match.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (done_s && !(&cnt_r)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output selection by output style.
  always_comb begin
    if (MOORE) begin
      match = (state_r == FULL_S);
    end else begin
      match = done_s & ~reset;
    end
  end

  assign match_cnt = cnt_r;
  assign cnt_sat   = &cnt_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed scoreboard bench for seq_detect_param over four configurations
// sharing one stimulus stream.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, din, clr_cnt;
  logic       m0, m1, m2, m3;
  logic       s0, s1, s2, s3;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  seq_detect_param u0 (.clk(clk), .reset(reset), .en(en), .din(din), .clr_cnt(clr_cnt),
                       .match(m0), .match_cnt(c0), .cnt_sat(s0));
  seq_detect_param #(.OVERLAP(1'b1)) u1 (.clk(clk), .reset(reset), .en(en), .din(din),
                       .clr_cnt(clr_cnt), .match(m1), .match_cnt(c1), .cnt_sat(s1));
  seq_detect_param #(.MOORE(1'b1)) u2 (.clk(clk), .reset(reset), .en(en), .din(din),
                       .clr_cnt(clr_cnt), .match(m2), .match_cnt(c2), .cnt_sat(s2));
  seq_detect_param #(.CNT_W(2), .OVERLAP(1'b1)) u3 (.clk(clk), .reset(reset), .en(en),
                       .din(din), .clr_cnt(clr_cnt), .match(m3), .match_cnt(c3), .cnt_sat(s3));

  localparam int K_M0 = 0, K_M1 = 1, K_M2 = 2, K_M3 = 3;
  localparam int K_C0 = 4, K_C1 = 5, K_C2 = 6, K_C3 = 7, K_S3 = 8, K_S0 = 9;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_M0:    return {31'd0, m0};
      K_M1:    return {31'd0, m1};
      K_M2:    return {31'd0, m2};
      K_M3:    return {31'd0, m3};
      K_C0:    return {24'd0, c0};
      K_C1:    return {24'd0, c1};
      K_C2:    return {24'd0, c2};
      K_C3:    return {30'd0, c3};
      K_S3:    return {31'd0, s3};
      K_S0:    return {31'd0, s0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int exp);
    exp_t x;
    x.tag  = tag;
    x.kind = kind;
    x.exp  = 32'(exp);
    sb.push_back(x);
  endtask

  // Drive one cycle, compare queued expectations at the falling edge, then
  // step past the rising edge.
  task automatic cyc(input logic r, input logic e, input logic d, input logic c);
    exp_t        x;
    logic [31:0] o;
    reset   = r;
    en      = e;
    din     = d;
    clr_cnt = c;
    @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.kind);
      n_cmp++;
      assert (o === x.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0]  st1;
    logic [4:0]  st3;
    logic [3:0]  st5;
    int          m;
    reset   = 1'b1;
    en      = 1'b0;
    din     = 1'b0;
    clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst();

    // Reset state of every configuration.
    push("rst_m0", K_M0, 0);
    push("rst_m1", K_M1, 0);
    push("rst_m2", K_M2, 0);
    push("rst_m3", K_M3, 0);
    push("rst_c0", K_C0, 0);
    push("rst_c3", K_C3, 0);
    push("rst_s0", K_S0, 0);
    push("rst_s3", K_S3, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 101010: non-overlap matches at bit 4 only, overlap at bits 4 and 6.
    st1 = 6'b101010;
    for (int i = 0; i < 6; i++) begin
      push($sformatf("nov_m_b%0d", i + 1), K_M0, (i == 3) ? 1 : 0);
      push($sformatf("ov_m_b%0d", i + 1), K_M1, (i == 3 || i == 5) ? 1 : 0);
      cyc(1'b0, 1'b1, st1[5-i], 1'b0);
    end
    push("nov_cnt", K_C0, 1);
    push("ov_cnt", K_C1, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 11010: Moore match the cycle after bit 5, held while en=0.
    rst();
    st3 = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      push($sformatf("moore_m_b%0d", i + 1), K_M2, 0);
      push($sformatf("mealy_m_b%0d", i + 1), K_M0, (i == 4) ? 1 : 0);
      cyc(1'b0, 1'b1, st3[4-i], 1'b0);
    end
    push("moore_hold_en0", K_M2, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    push("moore_m_after", K_M2, 1);
    push("moore_cnt", K_C2, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    push("moore_m_drop", K_M2, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // en gating: gaps with din toggling, including the final bit value.
    rst();
    push("gate_b1", K_M0, 0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    push("gate_b2", K_M0, 0); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    push("gate_b3", K_M0, 0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    push("gate_gap1", K_M0, 0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    push("gate_gap2", K_M0, 0); cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push("gate_gap3", K_M0, 0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    push("gate_b4", K_M0, 1); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    push("gate_cnt", K_C0, 1); cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-sequence discards the prefix; Mealy match forced low in reset.
    rst();
    push("mid_b1", K_M0, 0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    push("mid_b2", K_M0, 0); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    push("mid_b3", K_M0, 0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    push("mid_in_reset", K_M0, 0); cyc(1'b1, 1'b1, 1'b0, 1'b0);
    push("mid_after_rst", K_M0, 0); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    st5 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("mid_re_b%0d", i + 1), K_M0, (i == 3) ? 1 : 0);
      cyc(1'b0, 1'b1, st5[3-i], 1'b0);
    end
    push("mid_cnt", K_C0, 1); cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // CNT_W=2 overlap: matches on even bits from 4, counter saturates at 3.
    rst();
    for (int i = 1; i <= 13; i++) begin
      if (i <= 12) push($sformatf("sat_m_b%0d", i), K_M3, (i >= 4 && i % 2 == 0) ? 1 : 0);
      if (i >= 5) begin
        m = 0;
        for (int j = 4; j < i; j++) if (j % 2 == 0) m++;
        push($sformatf("sat_cnt_b%0d", i), K_C3, (m > 3) ? 3 : m);
        push($sformatf("sat_flag_b%0d", i), K_S3, (m >= 3) ? 1 : 0);
      end
      cyc(1'b0, 1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
    end
    push("clr_match", K_M3, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    push("clr_cnt", K_C3, 0);
    push("clr_flag", K_S3, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; the successor to the fixed 1010 detector.
- Scans a 1-bit serial stream for an arbitrary PAT_W-bit pattern.
- Pattern, overlap mode, output style (Mealy/Moore) and counter width are compile-time selectable.
- Keeps a saturating match counter; used as a framing/sync-word detector ahead of serial-to-parallel logic.

Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1010: pattern value; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 0: 0 = non-overlapping (restart from empty after a match); 1 = overlapping (a match suffix may start the next match).
- MOORE, 0: 0 = Mealy output (combinational, same cycle as final bit); 1 = Moore output (registered, cycle after final bit).
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample-valid; din is consumed only on edges where en=1.
- din  input  1  serial data bit.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  pattern detected (timing per MOORE).
- match_cnt  output  CNT_W  number of matches since reset/clear; saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (edge with reset=1):
  - state <- 0 (no prefix matched); match_cnt <- 0; cnt_sat <- 0.
  - Moore match register <- 0.
  - Mealy match is forced 0 while reset=1.
  - Reset overrides en, din and clr_cnt; reset mid-sequence discards the partial prefix.
- State = length of the longest matched prefix, width $clog2(PAT_W+1).
  - Mealy mode uses states 0..PAT_W-1.
  - Moore mode uses states 0..PAT_W; state PAT_W means "full match".
- Transitions, on an edge with en=1 from effective state s:
  - Expected bit e = PATTERN[PAT_W-1-s].
  - din==e -> s+1.
  - din!=e -> KMP fallback: the longest proper prefix of the pattern that is a suffix of (matched prefix ++ din), possibly 0.
  - The failure table is computed at elaboration from PATTERN; no runtime table.
- Completing a match:
  - Mealy: completing from state PAT_W-1 goes to 0 (OVERLAP=0) or fail(PAT_W) (OVERLAP=1), where fail(PAT_W) is the longest proper prefix that is also a suffix of PATTERN.
  - Moore: state PAT_W is entered. The next enabled bit is processed from effective state 0 (OVERLAP=0) or fail(PAT_W) (OVERLAP=1).
- en=0: state, counter and Moore match register hold. Mealy match=0.
- match output:
  - Mealy: match = en & ~reset & (state==PAT_W-1) & (din==PATTERN[0]); asserted in the cycle the final bit is presented, before the edge.
  - Moore: match = (state==PAT_W); high for exactly the cycle after the completing edge.
  - If the next edge has en=0, the Moore state holds, so match stays high until an enabled bit arrives.
- Counter:
  - Increments by 1 on every edge that completes a match (same edge in both modes).
  - Saturates at 2^CNT_W-1 and does not wrap; cnt_sat = &match_cnt.
  - clr_cnt=1 sets it to 0. clr_cnt and a completing match on the same edge -> 0 (clear wins).
- No X on outputs after the first reset edge.

Test Plan:
- Non-overlap, Mealy, defaults; stream 1,0,1,0,1,0 (en=1 each edge) -> match high only during bit 4; match_cnt=1 after bit 6.
- OVERLAP=1, Mealy; same stream -> match high during bits 4 and 6; match_cnt=2.
- MOORE=1, OVERLAP=0; stream 1,1,0,1,0 -> match high for one cycle after the edge sampling bit 5; match_cnt=1.
- en gating, defaults; bits 1,0,1 with en=1, then 3 cycles en=0 with din toggling, then 0 with en=1 -> single match on the final bit; no match during gaps.
- Reset mid-sequence, defaults; bits 1,0,1, reset 1 cycle, then 0 -> no match; then 1,0,1,0 -> match; match_cnt=1.
- CNT_W=2, OVERLAP=1, stream of six repeats of 1,0 -> match_cnt 1,2,3,3,3, cnt_sat=1 from the third match; clr_cnt coincident with a match -> match_cnt=0.
